// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory stage.
// Covers funct3 encodings, FSM states, response error codes and lane masks.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] M_B0 = 4'b0001;
  localparam logic [3:0] M_B1 = 4'b0010;
  localparam logic [3:0] M_B2 = 4'b0100;
  localparam logic [3:0] M_B3 = 4'b1000;
  localparam logic [3:0] M_H0 = 4'b0011;
  localparam logic [3:0] M_H1 = 4'b1100;
  localparam logic [3:0] M_W  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK    = 2'b00,
    ERR_MIS   = 2'b01,
    ERR_FAULT = 2'b10,
    ERR_ILL   = 2'b11
  } err_t;

  function automatic logic [3:0] lane_mask(
    input logic [1:0] lane
  );
    return M_B0 << lane;
  endfunction

endpackage

// File: rtl/lsu_mem_stage_lane_decode.sv
// Combinational funct3/lane decode into dmem lane strobes.
// Reports illegal-encoding and misalignment; range is checked by the caller.
import lsu_pkg::*;

module lsu_lane_decode (
  input  logic       we,
  input  logic [2:0] funct3,
  input  logic [1:0] lane,
  output logic [3:0] wmem,
  output logic [4:0] rmem,
  output err_t       err
);

  logic       is_b;
  logic       is_h;
  logic       is_w;
  logic       ill;
  logic       mis;
  logic       sext;
  logic [3:0] mask;

  always_comb begin
    is_b = (funct3[1:0] == 2'b00);
    is_h = (funct3[1:0] == 2'b01);
    is_w = (funct3[1:0] == 2'b10);
    mask = '0;
    mis  = 1'b0;
    unique case (1'b1)
      is_b: mask = lane_mask(lane);
      is_h: begin
        mask = lane[1] ? M_H1 : M_H0;
        mis  = lane[0];
      end
      is_w: begin
        mask = M_W;
        mis  = |lane;
      end
      default: mask = '0;
    endcase
  end

  always_comb begin
    if (we) begin
      ill = funct3[2] | (&funct3[1:0]);
    end else begin
      ill = (&funct3[1:0]) | (funct3[2] & funct3[1]);
    end
    sext = !we && ((funct3 == F3_LB) || (funct3 == F3_LH));
    if (ill) begin
      err = ERR_ILL;
    end else if (mis) begin
      err = ERR_MIS;
    end else begin
      err = ERR_OK;
    end
    wmem = (we && err == ERR_OK) ? mask : 4'b0000;
    rmem = (!we && err == ERR_OK) ? {sext, mask} : 5'b00000;
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-access stage: one load/store in flight, strobes dmem for a single
// cycle and returns one response; faulting requests bypass dmem entirely.
import lsu_pkg::*;

module lsu_mem_stage #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter logic [31:0] DMEM_BASE  = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic [3:0]  wmem,
  output logic [4:0]  rmem,
  output logic [31:0] mem_addr,
  output logic [31:0] store_data,
  input  logic [31:0] load_data
);

  state_t      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  err_t        resp_err_q, resp_err_d;
  logic [3:0]  wmem_q, wmem_d;
  logic [4:0]  rmem_q, rmem_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] store_data_q, store_data_d;

  logic [32:0] diff;
  logic [31:0] off;
  logic        fault;
  logic [3:0]  dec_wmem;
  logic [4:0]  dec_rmem;
  err_t        dec_err;
  err_t        acc_err;

  // Borrow out of the subtraction means the address sits below the base.
  assign diff  = {1'b0, req_addr} - {1'b0, DMEM_BASE};
  assign off   = diff[31:0];
  assign fault = diff[32] | (|off[31:ADDR_WIDTH+2]);

  lsu_lane_decode u_dec (
    .we     (req_we),
    .funct3 (req_funct3),
    .lane   (off[1:0]),
    .wmem   (dec_wmem),
    .rmem   (dec_rmem),
    .err    (dec_err)
  );

  always_comb begin
    if (dec_err != ERR_OK) begin
      acc_err = dec_err;
    end else if (fault) begin
      acc_err = ERR_FAULT;
    end else begin
      acc_err = ERR_OK;
    end
  end

  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    wmem_d       = wmem_q;
    rmem_d       = rmem_q;
    mem_addr_d   = mem_addr_q;
    store_data_d = store_data_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          if (acc_err != ERR_OK) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = acc_err;
            resp_rdata_d = '0;
          end else begin
            state_d    = ACCESS;
            mem_addr_d = {2'b00, off[31:2]};
            wmem_d     = dec_wmem;
            rmem_d     = dec_rmem;
            if (req_we) begin
              store_data_d = req_wdata;
            end
          end
        end
      end
      ACCESS: begin
        state_d      = RESP;
        wmem_d       = '0;
        rmem_d       = '0;
        resp_valid_d = 1'b1;
        resp_err_d   = ERR_OK;
        resp_rdata_d = (rmem_q != 5'b0) ? load_data : 32'h0;
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d      = IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        wmem_d       = '0;
        rmem_d       = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= ERR_OK;
      wmem_q       <= '0;
      rmem_q       <= '0;
      mem_addr_q   <= '0;
      store_data_q <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      wmem_q       <= wmem_d;
      rmem_q       <= rmem_d;
      mem_addr_q   <= mem_addr_d;
      store_data_q <= store_data_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign wmem       = wmem_q;
  assign rmem       = rmem_q;
  assign mem_addr   = mem_addr_q;
  assign store_data = store_data_q;

endmodule
